guineveer_mailbox: RTL and testbench

Synthesizable AXI4 write-only slave for the simulation mailbox, sitting directly on the LSU AXI bus downstream of the core.
- Decodes byte writes to the mailbox address into console characters and pass/fail end-of-test events.
- Buffers characters in a FIFO and streams them out over a valid/ready port for the bench console/log writer.
- Replaces the bench's combinational peeking of AW/W signals with a properly handshaken sink.

---
 rtl/guineveer_mailbox_pkg.sv | 24 ++
 rtl/guineveer_mailbox_fifo.sv | 47 ++++
 rtl/guineveer_mailbox.sv | 125 ++++++++++++
 tb/tb_guineveer_mailbox.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/guineveer_mailbox_pkg.sv
// rtl/guineveer_mailbox_pkg.sv - shared types and decode constants for the simulation mailbox
package guineveer_mailbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_W  = 3'd1,
    ST_WAIT_AW = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] CODE_PASS = 8'hFF;
  localparam logic [7:0] CODE_FAIL = 8'h01;
  localparam logic [7:0] CHAR_MIN  = 8'h06;
  localparam logic [7:0] CHAR_MAX  = 8'h7E;

  function automatic logic is_char(input logic [7:0] b);
    return (b >= CHAR_MIN) && (b <= CHAR_MAX);
  endfunction

endpackage

// File: rtl/guineveer_mailbox_fifo.sv
// rtl/guineveer_mailbox_fifo.sv - first-word-fall-through character FIFO
module guineveer_mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/guineveer_mailbox.sv
// rtl/guineveer_mailbox.sv - AXI4 write-only mailbox slave producing console chars and pass/fail
module guineveer_mailbox
  import guineveer_mailbox_pkg::*;
#(
  parameter int                ID_W         = 3,
  parameter int                ADDR_W       = 32,
  parameter int                DATA_W       = 64,
  parameter logic [ADDR_W-1:0] MAILBOX_ADDR = ADDR_W'(32'h80F8_0000),
  parameter int                FIFO_DEPTH   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic [ID_W-1:0]     bid_o,
  output logic [1:0]          bresp_o,
  output logic                char_valid_o,
  input  logic                char_ready_i,
  output logic [7:0]          char_data_o,
  output logic                pass_o,
  output logic                fail_o,
  output logic [15:0]         char_count_o
);

  state_t          state;
  logic            ready_en;
  logic [ID_W-1:0] aw_id;
  logic            aw_hit;
  logic [7:0]      w_byte;
  logic            w_lane0;
  logic            aw_fire;
  logic            w_fire;
  logic            printable;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            unused_bits;

  assign unused_bits = ^{wdata_i[DATA_W-1:8], wstrb_i[DATA_W/8-1:1]};

  // ready_en keeps both ready outputs low until the first edge after reset.
  assign awready_o = ready_en && ((state == ST_IDLE) || (state == ST_WAIT_AW));
  assign wready_o  = ready_en && ((state == ST_IDLE) || (state == ST_WAIT_W));
  assign aw_fire   = awvalid_i && awready_o;
  assign w_fire    = wvalid_i && wready_o;
  assign bvalid_o  = (state == ST_RESP);

  assign printable    = aw_hit && w_lane0 && is_char(w_byte);
  assign push         = (state == ST_EXEC) && printable && !fifo_full;
  assign char_valid_o = !fifo_empty;

  guineveer_mailbox_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (w_byte),
    .pop       (char_ready_i),
    .pop_data  (char_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      ready_en     <= 1'b0;
      aw_id        <= '0;
      aw_hit       <= 1'b0;
      w_byte       <= '0;
      w_lane0      <= 1'b0;
      bid_o        <= '0;
      bresp_o      <= RESP_OKAY;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      char_count_o <= '0;
    end else begin
      ready_en <= 1'b1;
      if (aw_fire) begin
        aw_id  <= awid_i;
        aw_hit <= (awaddr_i == MAILBOX_ADDR);
      end
      if (w_fire) begin
        w_byte  <= wdata_i[7:0];
        w_lane0 <= wstrb_i[0];
      end
      if (push) char_count_o <= char_count_o + 16'd1;

      case (state)
        ST_IDLE: begin
          if (aw_fire && w_fire) state <= ST_EXEC;
          else if (aw_fire)      state <= ST_WAIT_W;
          else if (w_fire)       state <= ST_WAIT_AW;
        end
        ST_WAIT_W:  if (w_fire)  state <= ST_EXEC;
        ST_WAIT_AW: if (aw_fire) state <= ST_EXEC;
        ST_EXEC: begin
          // A printable byte waits here until the FIFO has room.
          if (!(printable && fifo_full)) begin
            state   <= ST_RESP;
            bid_o   <= aw_id;
            bresp_o <= aw_hit ? RESP_OKAY : RESP_SLVERR;
            if (aw_hit && w_lane0) begin
              if (w_byte == CODE_PASS && !fail_o) pass_o <= 1'b1;
              if (w_byte == CODE_FAIL && !pass_o) fail_o <= 1'b1;
            end
          end
        end
        ST_RESP:    if (bready_i) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_guineveer_mailbox.sv
// tb/tb_guineveer_mailbox.sv - randomized self-checking bench for the mailbox slave
module tb_guineveer_mailbox;

  localparam logic [31:0] MB = 32'h80F8_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [2:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [2:0]  bid;
  logic [1:0]  bresp;
  logic        char_valid;
  logic        char_ready = 1'b0;
  logic [7:0]  char_data;
  logic        pass;
  logic        fail;
  logic [15:0] char_count;

  guineveer_mailbox dut (
    .clk_i(clk), .rst_i(rst),
    .awvalid_i(awvalid), .awready_o(awready), .awid_i(awid), .awaddr_i(awaddr),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bid_o(bid), .bresp_o(bresp),
    .char_valid_o(char_valid), .char_ready_i(char_ready), .char_data_o(char_data),
    .pass_o(pass), .fail_o(fail), .char_count_o(char_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the mailbox should have observed, in spec terms.
  logic [7:0]  exp_q[$];
  bit          m_pass = 0;
  bit          m_fail = 0;
  logic [15:0] m_count = '0;
  logic [1:0]  exp_resp;
  logic [2:0]  exp_id;

  task automatic model_reset();
    exp_q.delete();
    m_pass  = 0;
    m_fail  = 0;
    m_count = '0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [7:0] data,
                             input logic [7:0] strb, input logic [2:0] id);
    exp_id = id;
    if (addr != MB) begin
      exp_resp = 2'b10;
    end else begin
      exp_resp = 2'b00;
      if (strb[0]) begin
        if (data == 8'hFF) begin
          if (!m_fail) m_pass = 1;
        end else if (data == 8'h01) begin
          if (!m_pass) m_fail = 1;
        end else if (data >= 8'h06 && data <= 8'h7E) begin
          exp_q.push_back(data);
          m_count = m_count + 16'd1;
        end
      end
    end
  endtask

  // Consumer: 0 random ready, 1 held low, 2 held high, 3 exactly one pop then low.
  int ready_mode = 0;
  always @(negedge clk) begin
    case (ready_mode)
      0:       char_ready = 1'($urandom_range(0, 1));
      1:       char_ready = 1'b0;
      default: char_ready = 1'b1;
    endcase
    if (!rst && char_valid && char_ready) begin
      if (exp_q.size() == 0) check_eq("char_extra", {24'h0, char_data}, 32'h100);
      else check_eq("char_data", {24'h0, char_data}, {24'h0, exp_q.pop_front()});
      if (ready_mode == 3) ready_mode = 1;
    end
  end

  bit bready_rand = 0;

  task automatic send(input logic [31:0] addr, input logic [7:0] data, input logic [7:0] strb,
                      input logic [2:0] id, input int order, input int gap);
    bit aw_pend = 1;
    bit w_pend = 1;
    bit awf, wf;
    int c = 0;
    model_write(addr, data, strb, id);
    awid   = id;
    awaddr = addr;
    wdata  = {$urandom(), $urandom()};
    wdata[7:0] = data;
    wstrb  = strb;
    while ((aw_pend || w_pend) && c < 50) begin
      @(negedge clk);
      awvalid = aw_pend && (order != 2 || c >= gap);
      wvalid  = w_pend && (order != 1 || c >= gap);
      awf = awvalid && awready;
      wf  = wvalid && wready;
      @(posedge clk);
      #1;
      if (awf) begin aw_pend = 0; awvalid = 1'b0; end
      if (wf)  begin w_pend = 0;  wvalid = 1'b0; end
      c++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_eq("aw_w_accepted", 32'(aw_pend | w_pend), 32'd0);
  endtask

  task automatic wait_b(output int lat);
    bit done = 0;
    lat = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      lat++;
      bready = bready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid && bready) begin
        check_eq("bresp", 32'(bresp), 32'(exp_resp));
        check_eq("bid", 32'(bid), 32'(exp_id));
        @(posedge clk);
        #1;
        bready = 1'b0;
        done = 1;
      end
    end
    bready = 1'b0;
    check_eq("b_received", 32'(done), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] data, input logic [7:0] strb,
                          input logic [2:0] id, input int order, input int gap, output int lat);
    send(addr, data, strb, id, order, gap);
    wait_b(lat);
    check_eq("pass", 32'(pass), 32'(m_pass));
    check_eq("fail", 32'(fail), 32'(m_fail));
    check_eq("char_count", 32'(char_count), 32'(m_count));
  endtask

  task automatic drain();
    ready_mode = 2;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check_eq("drain_left", exp_q.size(), 32'd0);
    check_eq("drain_valid", 32'(char_valid), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit seen;
    logic [15:0] cnt0;
    logic [7:0]  d;
    logic [31:0] a;
    logic [7:0]  s;

    repeat (3) @(negedge clk);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_bid", 32'(bid), 32'd0);
    check_eq("rst_bresp", 32'(bresp), 32'd0);
    check_eq("rst_char_valid", 32'(char_valid), 32'd0);
    check_eq("rst_char_data", 32'(char_data), 32'd0);
    check_eq("rst_pass_fail", 32'({pass, fail}), 32'd0);
    check_eq("rst_count", 32'(char_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'({awready, wready}), 32'd3);

    // Directed: simultaneous AW+W, two-cycle B latency.
    ready_mode = 1;
    do_write(MB, 8'h41, 8'h01, 3'd2, 0, 0, lat);
    check_eq("b_latency", lat, 32'd2);
    check_eq("count_one", 32'(char_count), 32'd1);
    drain();

    // W leads AW by three cycles.
    do_write(MB, 8'h0A, 8'hFF, 3'd1, 2, 3, lat);
    drain();

    // Wrong address: SLVERR, id echoed, no side effects.
    cnt0 = char_count;
    do_write(MB + 32'd4, 8'h41, 8'h01, 3'd5, 0, 0, lat);
    check_eq("slverr_no_push", 32'(char_count), 32'(cnt0));
    check_eq("slverr_char_valid", 32'(char_valid), 32'd0);

    // Randomized traffic against the model.
    ready_mode = 0;
    bready_rand = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 11))
        0:       d = 8'hFF;
        1:       d = 8'h01;
        2:       d = 8'($urandom());
        3:       d = 8'h05;
        4:       d = 8'h7F;
        5:       d = 8'h06;
        6:       d = 8'h7E;
        default: d = 8'($urandom_range(6, 126));
      endcase
      a = ($urandom_range(0, 7) == 0) ? (MB + 32'd4) : MB;
      s = 8'($urandom());
      if ($urandom_range(0, 7) != 0) s[0] = 1'b1;
      do_write(a, d, s, 3'($urandom()), $urandom_range(0, 2), $urandom_range(0, 3), lat);
    end
    bready_rand = 0;
    drain();

    // Full FIFO: the 17th write stalls until one pop.
    ready_mode = 1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) do_write(MB, 8'h61 + 8'(i), 8'h01, 3'd3, 0, 0, lat);
    send(MB, 8'h71, 8'h01, 3'd4, 0, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= bvalid;
    end
    check_eq("full_b_withheld", 32'(seen), 32'd0);
    check_eq("full_count_held", 32'(char_count), 32'(m_count - 16'd1));
    ready_mode = 3;
    wait_b(lat);
    check_eq("full_count_after", 32'(char_count), 32'(m_count));
    drain();

    // Reset while holding a B response and a queued character.
    ready_mode = 1;
    send(MB, 8'h5A, 8'h01, 3'd6, 0, 0);
    for (int i = 0; i < 10 && !bvalid; i++) @(negedge clk);
    check_eq("resp_reached", 32'(bvalid), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check_eq("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_mid_fifo", 32'(char_valid), 32'd0);
    check_eq("rst_mid_count", 32'(char_count), 32'd0);
    check_eq("rst_mid_ready", 32'({awready, wready}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_ready_up", 32'({awready, wready}), 32'd3);
    ready_mode = 0;
    do_write(MB, 8'h42, 8'h01, 3'd7, 1, 2, lat);
    drain();

    // Verdicts: first one wins; out-of-range bytes are dropped.
    do_write(MB, 8'h01, 8'h01, 3'd0, 0, 0, lat);
    do_write(MB, 8'hFF, 8'h01, 3'd0, 0, 0, lat);
    check_eq("fail_wins", 32'({pass, fail}), 32'd1);
    cnt0 = char_count;
    do_write(MB, 8'h05, 8'h01, 3'd1, 0, 0, lat);
    do_write(MB, 8'h7F, 8'h01, 3'd1, 0, 0, lat);
    check_eq("nonprint_dropped", 32'(char_count), 32'(cnt0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
